fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control FSM for the instruction-fetch front end. It drives the `ProgramCounter` enable and jump controls and runs a request/acknowledge fetch on the instruction memory port. It presents each fetched word to decode with a valid/ready handshake and handles branch redirects and halt. It sits between `ProgramCounter`, instruction memory and the decode stage.

## Interface
Parameters:
- `XLEN`, 32, address/instruction width
- `TIMEOUT_CYCLES`, 16, watchdog limit; used only with `FETCH_TIMEOUT_EN`

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `pc_in`  in  XLEN  current PC from `ProgramCounter`
- `pc_en`  out  1  PC advance (+4) strobe
- `pc_jmp`  out  1  PC relative-jump strobe
- `pc_imm12`  out  12  jump offset, bits [12:1]
- `br_req`  in  1  redirect request from execute (single-cycle pulse)
- `br_imm12`  in  12  redirect offset, valid with `br_req`
- `halt_req`  in  1  stop fetching (level)
- `imem_req`  out  1  fetch request
- `imem_addr`  out  XLEN  fetch address
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid
- `imem_rdata`  in  XLEN  fetched word
- `instr_valid`  out  1  instruction available to decode
- `instr_ready`  in  1  decode accepts
- `instr_out`  out  XLEN  instruction word
- `instr_pc`  out  XLEN  address of `instr_out`
- `busy`  out  1  state is not IDLE and not HALT
- `fetch_err`  out  1  sticky watchdog error

## Operation
- States: IDLE, FETCH, OUT, REDIR, HALT.
- Reset: state IDLE. All outputs are 0, `redir_pend` is 0 and the latched offset is 0.
- IDLE → FETCH on the first clock edge after reset is released.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc_in`; both held stable until `imem_ack`.
  - On ack with no pending redirect: capture `imem_rdata`→`instr_out` and `imem_addr`→`instr_pc`, pulse `pc_en` in the ack cycle, go to OUT.
- OUT:
  - `instr_valid`=1 with stable data until `instr_ready`.
  - On `instr_ready`: go to HALT if `halt_req`=1, otherwise FETCH.
- Redirect (`br_req` in any state except HALT):
  - Latch `br_imm12` and set `redir_pend`.
  - In FETCH, the bus transaction is never aborted. The request completes, the data is discarded, `pc_en` is not pulsed, then go to REDIR.
  - In OUT, `instr_valid` drops on the next edge, then go to REDIR.
- REDIR: `pc_jmp`=1 for exactly one cycle with `pc_imm12` set to the latched offset and `pc_en`=0. Clear `redir_pend`, then go to FETCH.
- Halt: `halt_req` is honoured only at instruction boundaries (after acceptance in OUT, or in IDLE). HALT is terminal until reset; `br_req` is ignored there.
- Priority:
  - `br_req` together with `instr_ready` in OUT: the instruction is consumed, then REDIR.
  - `br_req` together with `imem_ack`: the data is discarded and the redirect wins.
  - Redirect wins over halt.
- A second `br_req` while one is pending overwrites the latched offset (last one wins).
- `pc_en` and `pc_jmp` are never high in the same cycle.

## Timing
- Ack in cycle N → `instr_valid` in N+1.
- `instr_ready` in cycle M → `imem_req` in M+1, with `imem_addr` already showing the incremented PC.
- Steady-state throughput: 1 instruction per 2 cycles with zero-wait memory.
- Redirect during OUT at cycle M → REDIR at M+1 → FETCH at the new target at M+2.
- Asynchronous reset mid-transaction drops `imem_req` and `instr_valid` immediately. Memory must tolerate a request withdrawn by reset.

## Configuration
- With `FETCH_TIMEOUT_EN` defined:
  - A counter runs in FETCH.
  - If `TIMEOUT_CYCLES` elapse without `imem_ack`: deassert `imem_req`, set `fetch_err` (sticky until reset), go to HALT.
- Without it: no counter is built and `fetch_err` is tied to 0.

## Structure
- Package `fetch_pkg` holds:
  - the state enum `fetch_state_t`
  - the `IMM_W`=12 constant
  - the default `XLEN`
- Sub-module `fetch_watchdog`: a `TIMEOUT_CYCLES` counter with clear/enable/expire. It is instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- **Reset and fetch:** release reset with `pc_in`=0, ack after 2 wait cycles, data 32'h00400093 → `instr_out`=32'h00400093, `instr_pc`=0, one `pc_en` pulse, `instr_valid` held until ready.
- **Back-to-back fetch:** zero-wait memory, `instr_ready` held at 1 → `imem_addr` sequence 0, 4, 8, 12, one `imem_req` every 2 cycles.
- **Redirect during OUT:** `br_req` with `br_imm12`=12'h004 → `instr_valid` drops, one `pc_jmp` cycle with `pc_imm12`=12'h004, no `pc_en`, next fetch at the new PC.
- **Redirect while waiting for ack:** `br_req` mid-FETCH, ack arrives 3 cycles later → data never shows as valid, `pc_en` not pulsed, followed by REDIR.
- **Halt at a boundary:** `halt_req`=1 during OUT, then `instr_ready` → HALT, `busy`=0, no further `imem_req`; a later `br_req` is ignored.
- **Watchdog (`FETCH_TIMEOUT_EN`):** never ack → `imem_req` drops after 16 cycles, `fetch_err`=1, HALT. Without the macro, `fetch_err` stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional watchdog is enabled by defining FETCH_TIMEOUT_EN.
package fetch_pkg;

    localparam int IMM_W        = 12;
    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        OUT,
        REDIR,
        HALT
    } fetch_state_t;

    function automatic logic is_busy(input fetch_state_t s);
        return (s != IDLE) && (s != HALT);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of PC-control, instruction-memory and decode-handshake signals.
// master = fetch_sequencer side, slave = surrounding PC / memory / decode.
interface fetch_sequencer_if #(
    parameter int XLEN = fetch_pkg::XLEN_DEFAULT
);
    import fetch_pkg::*;

    logic [XLEN-1:0]  pc_in;
    logic             pc_en;
    logic             pc_jmp;
    logic [IMM_W-1:0] pc_imm12;
    logic             br_req;
    logic [IMM_W-1:0] br_imm12;
    logic             halt_req;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ack;
    logic [XLEN-1:0]  imem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [XLEN-1:0]  instr_out;
    logic [XLEN-1:0]  instr_pc;
    logic             busy;
    logic             fetch_err;

    modport master (
        input  pc_in, br_req, br_imm12, halt_req, imem_ack, imem_rdata, instr_ready,
        output pc_en, pc_jmp, pc_imm12, imem_req, imem_addr,
               instr_valid, instr_out, instr_pc, busy, fetch_err
    );

    modport slave (
        output pc_in, br_req, br_imm12, halt_req, imem_ack, imem_rdata, instr_ready,
        input  pc_en, pc_jmp, pc_imm12, imem_req, imem_addr,
               instr_valid, instr_out, instr_pc, busy, fetch_err
    );

endinterface

// File: rtl/fetch_watchdog.sv
// Cycle counter that flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expire_o = enable_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expire_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: PC strobes, imem req/ack, decode valid/ready,
// branch redirect and halt. Define FETCH_TIMEOUT_EN to build the fetch watchdog.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_sequencer_if.master  bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_t     state_q, state_d;
    logic             redir_pend_q, redir_pend_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  ipc_q, ipc_d;

    logic pc_en;
    logic pc_jmp;
    logic imem_req;

`ifdef FETCH_TIMEOUT_EN
    logic fetch_err_q, fetch_err_d;
    logic wd_expire;

    // Counter restarts on every new FETCH and whenever the memory answers.
    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  ((state_q != FETCH) || bus.imem_ack),
        .enable_i (state_q == FETCH),
        .expire_o (wd_expire)
    );
`endif

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d      = state_q;
        redir_pend_d = redir_pend_q;
        imm_d        = imm_q;
        instr_d      = instr_q;
        ipc_d        = ipc_q;
        pc_en        = 1'b0;
        pc_jmp       = 1'b0;
        imem_req     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        fetch_err_d  = fetch_err_q;
`endif

        // A later redirect overwrites an earlier one still pending.
        if (bus.br_req && (state_q != HALT)) begin
            redir_pend_d = 1'b1;
            imm_d        = bus.br_imm12;
        end

        case (state_q)
            IDLE: begin
                state_d = (bus.halt_req && !bus.br_req) ? HALT : FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    // The bus cycle always completes; a redirect just discards the word.
                    if (redir_pend_q || bus.br_req) begin
                        state_d = REDIR;
                    end else begin
                        instr_d = bus.imem_rdata;
                        ipc_d   = bus.pc_in;
                        pc_en   = 1'b1;
                        state_d = OUT;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wd_expire) begin
                    fetch_err_d = 1'b1;
                    state_d     = HALT;
                end
`endif
            end

            OUT: begin
                if (bus.br_req) begin
                    state_d = REDIR;
                end else if (bus.instr_ready) begin
                    state_d = bus.halt_req ? HALT : FETCH;
                end
            end

            REDIR: begin
                pc_jmp = 1'b1;
                if (!bus.br_req) begin
                    redir_pend_d = 1'b0;
                end
                state_d = FETCH;
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    // NOTE: the instruction and PC holding registers are reset as well, because
    // the decode-facing outputs must read zero while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            redir_pend_q <= 1'b0;
            imm_q        <= '0;
            instr_q      <= '0;
            ipc_q        <= '0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
            imm_q        <= imm_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end

    assign bus.fetch_err = fetch_err_q;
`else
    assign bus.fetch_err = 1'b0;
`endif

    assign bus.pc_en       = pc_en;
    assign bus.pc_jmp      = pc_jmp;
    assign bus.pc_imm12    = pc_jmp ? imm_q : '0;
    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = imem_req ? bus.pc_in : '0;
    assign bus.instr_valid = (state_q == OUT);
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.busy        = is_busy(state_q);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with PC and instruction-memory models.
// Watchdog expectations follow FETCH_TIMEOUT_EN.
module tb_fetch_sequencer;

    logic clk;
    logic reset_n;

    fetch_sequencer_if #(.XLEN(32)) bus();

    fetch_sequencer #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] br_off(input logic [11:0] imm);
        return {{19{imm[11]}}, imm, 1'b0};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h00400093;
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // ProgramCounter model
    logic [31:0] pc_q;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        pc_q <= 32'd0;
        else if (bus.pc_en)  pc_q <= pc_q + 32'd4;
        else if (bus.pc_jmp) pc_q <= pc_q + br_off(bus.pc_imm12);
    end
    assign bus.pc_in = pc_q;

    // Instruction memory: ack after mem_wait cycles of request (-1 = never)
    int mem_wait = 0;
    bit mem_rand = 0;
    int wait_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!reset_n || !bus.imem_req) begin
            bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; wait_cnt = 0;
        end else if (mem_wait >= 0 && wait_cnt >= mem_wait) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(bus.imem_addr); wait_cnt = 0;
            if (mem_rand) mem_wait = $urandom_range(0, 3);
        end else begin
            bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; wait_cnt++;
        end
    end

    // Monitor: event log, protocol invariants and (optionally) stream model
    int          cyc, n_pc_en, n_pc_jmp, ack_cyc, valid_cyc;
    logic [11:0] last_imm;
    logic [31:0] req_addr[$];
    int          req_cyc[$];
    logic [31:0] acc_pc[$];
    bit          model_en;
    logic [31:0] exp_pc;
    bit          mon_acc;
    logic        prev_req, prev_ack, prev_valid, prev_ready, prev_br;
    logic [31:0] prev_addr, prev_out, prev_pc;

    always @(negedge clk) begin
        if (reset_n) begin
            cyc++;
            checks++;
            if (bus.pc_en && bus.pc_jmp) begin
                failures++;
                $display("FAIL pc_strobe_excl: cyc=%0d pc_en=%b pc_jmp=%b, required not both 1", cyc, bus.pc_en, bus.pc_jmp);
            end
            if (bus.pc_en) n_pc_en++;
            if (bus.pc_jmp) begin n_pc_jmp++; last_imm = bus.pc_imm12; end
            if (bus.imem_req && !prev_req) begin req_addr.push_back(bus.imem_addr); req_cyc.push_back(cyc); end
            if (bus.imem_req && bus.imem_ack) ack_cyc = cyc;
            if (bus.instr_valid && !prev_valid) valid_cyc = cyc;
            if (prev_req && !prev_ack && bus.imem_req) begin
                checks++;
                if (bus.imem_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL req_stable: cyc=%0d addr=%h required %h", cyc, bus.imem_addr, prev_addr);
                end
            end
            if (prev_valid && !prev_ready && !prev_br && bus.instr_valid) begin
                checks++;
                if ({bus.instr_out, bus.instr_pc} !== {prev_out, prev_pc}) begin
                    failures++;
                    $display("FAIL out_stable: cyc=%0d out=%h pc=%h required %h %h", cyc, bus.instr_out, bus.instr_pc, prev_out, prev_pc);
                end
            end
            mon_acc = bus.instr_valid && bus.instr_ready;
            if (mon_acc) begin
                acc_pc.push_back(bus.instr_pc);
                if (model_en) begin
                    checks++;
                    if (bus.instr_pc !== exp_pc || bus.instr_out !== mem_word(exp_pc)) begin
                        failures++;
                        $display("FAIL stream: cyc=%0d pc=%h word=%h required pc=%h word=%h", cyc, bus.instr_pc, bus.instr_out, exp_pc, mem_word(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (model_en && bus.br_req && (bus.instr_valid || bus.imem_req)) begin
                if (bus.instr_valid && !mon_acc) exp_pc = exp_pc + 32'd4;
                exp_pc = exp_pc + br_off(bus.br_imm12);
            end
            prev_req = bus.imem_req; prev_ack = bus.imem_ack; prev_addr = bus.imem_addr;
            prev_valid = bus.instr_valid; prev_ready = bus.instr_ready; prev_br = bus.br_req;
            prev_out = bus.instr_out; prev_pc = bus.instr_pc;
        end
    end

    task automatic drive_slot();  @(posedge clk); #1; endtask
    task automatic sample_slot(); @(negedge clk); #1; endtask

    task automatic enter_reset();
        reset_n = 1'b0;
        bus.instr_ready = 1'b0; bus.br_req = 1'b0; bus.br_imm12 = 12'd0; bus.halt_req = 1'b0;
        mem_wait = 0; mem_rand = 0; model_en = 0; exp_pc = 32'd0;
        repeat (2) @(posedge clk);
        cyc = 0; n_pc_en = 0; n_pc_jmp = 0; ack_cyc = 0; valid_cyc = 0; last_imm = 12'd0;
        req_addr.delete(); req_cyc.delete(); acc_pc.delete();
        prev_req = 0; prev_ack = 0; prev_valid = 0; prev_ready = 0; prev_br = 0;
        prev_addr = 0; prev_out = 0; prev_pc = 0;
    endtask

    task automatic leave_reset();
        @(negedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic do_reset();
        enter_reset();
        leave_reset();
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            sample_slot();
            if (bus.instr_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL wait_valid: instr_valid=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic test_reset();
        enter_reset();
        checks++;
        if ({bus.imem_req, bus.instr_valid, bus.pc_en, bus.pc_jmp, bus.busy, bus.fetch_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: req/valid/en/jmp/busy/err=%b required 000000",
                     {bus.imem_req, bus.instr_valid, bus.pc_en, bus.pc_jmp, bus.busy, bus.fetch_err});
        end
        checks++;
        if ({bus.imem_addr, bus.instr_out, bus.instr_pc, bus.pc_imm12} !== 108'd0) begin
            failures++;
            $display("FAIL reset_data: addr=%h out=%h pc=%h imm=%h required all 0", bus.imem_addr, bus.instr_out, bus.instr_pc, bus.pc_imm12);
        end
        mem_wait = -1;
        leave_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_release: busy=%b req=%b required 0 0", bus.busy, bus.imem_req);
        end
        sample_slot();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL first_fetch: req=%b addr=%h busy=%b required 1 0 1", bus.imem_req, bus.imem_addr, bus.busy);
        end
    endtask

    task automatic test_fetch_basic();
        bit ok;
        enter_reset();
        mem_wait = 2;
        leave_reset();
        wait_valid(20, ok);
        checks++;
        if (bus.instr_out !== 32'h00400093 || bus.instr_pc !== 32'd0) begin
            failures++;
            $display("FAIL fetch_data: out=%h pc=%h required 00400093 00000000", bus.instr_out, bus.instr_pc);
        end
        checks++;
        if (ack_cyc !== 3 || valid_cyc !== 4) begin
            failures++;
            $display("FAIL fetch_latency: ack_cyc=%0d valid_cyc=%0d required 3 4", ack_cyc, valid_cyc);
        end
        for (int i = 0; i < 3; i++) begin
            sample_slot();
            checks++;
            if (bus.instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL valid_hold: valid=%b required 1", bus.instr_valid);
            end
        end
        drive_slot(); bus.instr_ready = 1'b1; sample_slot();
        drive_slot(); bus.instr_ready = 1'b0; sample_slot();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd4) begin
            failures++;
            $display("FAIL next_fetch: valid=%b req=%b addr=%h required 0 1 00000004", bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        checks++;
        if (n_pc_en !== 1) begin
            failures++;
            $display("FAIL pc_en_count: got %0d required 1", n_pc_en);
        end
    endtask

    task automatic test_back_to_back();
        enter_reset();
        mem_wait = 0;
        bus.instr_ready = 1'b1;
        leave_reset();
        repeat (10) sample_slot();
        checks++;
        if (req_addr.size() < 4) begin
            failures++;
            $display("FAIL b2b_count: requests=%0d required >=4", req_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (req_addr[i] !== 32'(4 * i) || (i > 0 && req_cyc[i] - req_cyc[i-1] != 2)) begin
                    failures++;
                    $display("FAIL b2b_req%0d: addr=%h gap=%0d required %h 2", i, req_addr[i],
                             (i > 0) ? req_cyc[i] - req_cyc[i-1] : 2, 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect_out();
        bit ok;
        do_reset();
        wait_valid(20, ok);
        drive_slot(); bus.br_req = 1'b1; bus.br_imm12 = 12'h004; sample_slot();
        drive_slot(); bus.br_req = 1'b0; sample_slot();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.pc_jmp !== 1'b1 || bus.pc_imm12 !== 12'h004 || bus.pc_en !== 1'b0) begin
            failures++;
            $display("FAIL redir_out: valid=%b jmp=%b imm=%h en=%b required 0 1 004 0", bus.instr_valid, bus.pc_jmp, bus.pc_imm12, bus.pc_en);
        end
        sample_slot();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd12 || n_pc_jmp !== 1) begin
            failures++;
            $display("FAIL redir_target: req=%b addr=%h jmps=%0d required 1 0000000c 1", bus.imem_req, bus.imem_addr, n_pc_jmp);
        end
    endtask

    task automatic test_redirect_fetch();
        bit ok;
        bit saw_valid;
        int jmp_at;
        saw_valid = 0; jmp_at = 0;
        enter_reset();
        mem_wait = 4;
        leave_reset();
        sample_slot();
        drive_slot(); bus.br_req = 1'b1; bus.br_imm12 = 12'h010; sample_slot();
        drive_slot(); bus.br_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_slot();
            if (bus.instr_valid) saw_valid = 1;
            if (bus.pc_jmp) jmp_at = cyc;
        end
        checks++;
        if (saw_valid || n_pc_en !== 0 || ack_cyc !== 5 || jmp_at !== 6 || last_imm !== 12'h010) begin
            failures++;
            $display("FAIL redir_fetch: valid_seen=%b pc_en=%0d ack_cyc=%0d jmp_cyc=%0d imm=%h required 0 0 5 6 010",
                     saw_valid, n_pc_en, ack_cyc, jmp_at, last_imm);
        end
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd32) begin
            failures++;
            $display("FAIL redir_fetch_target: req=%b addr=%h required 1 00000020", bus.imem_req, bus.imem_addr);
        end
        bus.instr_ready = 1'b1;
        wait_valid(20, ok);
        checks++;
        if (bus.instr_pc !== 32'd32 || bus.instr_out !== mem_word(32'd32)) begin
            failures++;
            $display("FAIL redir_fetch_data: pc=%h out=%h required 00000020 %h", bus.instr_pc, bus.instr_out, mem_word(32'd32));
        end
    endtask

    task automatic test_halt();
        bit ok;
        int bad;
        bad = 0;
        do_reset();
        wait_valid(20, ok);
        drive_slot(); bus.halt_req = 1'b1; sample_slot();
        drive_slot(); bus.instr_ready = 1'b1; sample_slot();
        drive_slot(); bus.instr_ready = 1'b0; sample_slot();
        checks++;
        if (bus.busy !== 1'b0 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_enter: busy=%b req=%b valid=%b required 0 0 0", bus.busy, bus.imem_req, bus.instr_valid);
        end
        drive_slot(); bus.br_req = 1'b1; bus.br_imm12 = 12'h005; sample_slot();
        drive_slot(); bus.br_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample_slot();
            if (bus.imem_req || bus.pc_jmp || bus.busy) bad++;
        end
        checks++;
        if (bad != 0 || n_pc_jmp !== 0 || req_addr.size() != 1) begin
            failures++;
            $display("FAIL halt_terminal: active_cycles=%0d jmps=%0d requests=%0d required 0 0 1", bad, n_pc_jmp, req_addr.size());
        end
        // halt requested before the first fetch
        enter_reset();
        bus.halt_req = 1'b1;
        leave_reset();
        repeat (4) sample_slot();
        checks++;
        if (bus.busy !== 1'b0 || req_addr.size() != 0) begin
            failures++;
            $display("FAIL halt_idle: busy=%b requests=%0d required 0 0", bus.busy, req_addr.size());
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        enter_reset();
        mem_wait = -1;
        leave_reset();
        sample_slot();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_fetch: req=%b addr=%h busy=%b required 0 0 0", bus.imem_req, bus.imem_addr, bus.busy);
        end
        do_reset();
        wait_valid(20, ok);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr_out !== 32'd0) begin
            failures++;
            $display("FAIL async_reset_out: valid=%b out=%h required 0 0", bus.instr_valid, bus.instr_out);
        end
    endtask

    task automatic test_watchdog();
        int req_cycles;
        req_cycles = 0;
        enter_reset();
        mem_wait = -1;
        leave_reset();
        for (int i = 0; i < 40; i++) begin
            sample_slot();
            if (bus.imem_req) req_cycles++;
        end
`ifdef FETCH_TIMEOUT_EN
        checks++;
        if (req_cycles != 16 || bus.fetch_err !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL watchdog: req_cycles=%0d err=%b busy=%b required 16 1 0", req_cycles, bus.fetch_err, bus.busy);
        end
`else
        checks++;
        if (req_cycles != 40 || bus.fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL no_watchdog: req_cycles=%0d err=%b required 40 0", req_cycles, bus.fetch_err);
        end
`endif
    endtask

    task automatic test_random_stream();
        bit br_busy;
        br_busy = 0;
        enter_reset();
        mem_rand = 1;
        mem_wait = $urandom_range(0, 3);
        model_en = 1;
        exp_pc = 32'd0;
        leave_reset();
        for (int i = 0; i < 600; i++) begin
            drive_slot();
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.br_req = 1'b0;
            if (bus.pc_jmp) br_busy = 0;
            if (!br_busy && (bus.instr_valid || bus.imem_req) && $urandom_range(0, 15) == 0) begin
                bus.br_req   = 1'b1;
                bus.br_imm12 = 12'($urandom_range(0, 4095));
                br_busy      = 1;
            end
        end
        sample_slot();
        model_en = 0;
        checks++;
        if (acc_pc.size() < 40) begin
            failures++;
            $display("FAIL random_progress: accepted=%0d required >=40", acc_pc.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_fetch_basic();
        test_back_to_back();
        test_redirect_out();
        test_redirect_fetch();
        test_halt();
        test_async_reset();
        test_watchdog();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
